// File: rtl/reg_writeback_arbiter.sv
// Merges pipeline writebacks and MUL/DIV results onto the single register-file write port; optional WB_BYPASS_EN adds an empty-FIFO MD bypass.
// Latency: pipe 1 cycle; MD 1 cycle via bypass, otherwise 2+ cycles through the FIFO (pipe always has priority).
// Backpressure: MD_READY drops while the FIFO is full; the pipeline never stalls.
module reg_writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         PIPE_WRITE,
    input  logic [ADDR_WIDTH-1:0]        PIPE_ADDR,
    input  logic [DATA_WIDTH-1:0]        PIPE_DATA,
    input  logic                         MD_VALID,
    output logic                         MD_READY,
    input  logic [ADDR_WIDTH-1:0]        MD_ADDR,
    input  logic [DATA_WIDTH-1:0]        MD_DATA,
    output logic [DATA_WIDTH-1:0]        IN,
    output logic [ADDR_WIDTH-1:0]        INADDRESS,
    output logic                         WRITE,
    output logic [(1<<ADDR_WIDTH)-1:0]   PENDING,
    output logic [$clog2(DEPTH):0]       COUNT
);
    localparam int PW   = $clog2(DEPTH);
    localparam int NREG = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      live_q, live_nxt;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [NREG-1:0]       pending_nxt;
    logic                  xfer, pipe_req, md_req, fifo_empty, pop, push, push_live, bypass;

    assign MD_READY   = RESET & (COUNT != (PW+1)'(DEPTH));
    assign xfer       = MD_VALID & MD_READY;
    assign pipe_req   = PIPE_WRITE & (PIPE_ADDR != '0);
    assign md_req     = xfer & (MD_ADDR != '0);
    assign fifo_empty = (COUNT == '0);
    assign pop        = ~pipe_req & ~fifo_empty;
`ifdef WB_BYPASS_EN
    assign bypass     = md_req & ~pipe_req & fifo_empty;
`else
    assign bypass     = 1'b0;
`endif
    assign push       = md_req & ~bypass;
    // A pipe write in the same cycle is newer than the MD result, so the push lands dead.
    assign push_live  = ~(pipe_req & (PIPE_ADDR == MD_ADDR));

    always_comb begin
        live_nxt = live_q;
        if (pipe_req) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == PIPE_ADDR) live_nxt[i] = 1'b0;
            end
        end
        if (pop)  live_nxt[rd_ptr] = 1'b0;
        if (push) live_nxt[wr_ptr] = push_live;
    end

    always_comb begin
        pending_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_nxt[i]) begin
                if (push && wr_ptr == PW'(i)) pending_nxt[MD_ADDR]   = 1'b1;
                else                          pending_nxt[addr_q[i]] = 1'b1;
            end
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            addr_q[wr_ptr] <= MD_ADDR;
            data_q[wr_ptr] <= MD_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            COUNT     <= '0;
            live_q    <= '0;
            PENDING   <= '0;
            IN        <= '0;
            INADDRESS <= '0;
            WRITE     <= 1'b0;
        end else begin
            live_q  <= live_nxt;
            PENDING <= pending_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   COUNT <= COUNT + 1'b1;
                2'b01:   COUNT <= COUNT - 1'b1;
                default: COUNT <= COUNT;
            endcase
            if (pipe_req) begin
                WRITE     <= 1'b1;
                IN        <= PIPE_DATA;
                INADDRESS <= PIPE_ADDR;
            end else if (pop) begin
                WRITE <= live_q[rd_ptr];
                if (live_q[rd_ptr]) begin
                    IN        <= data_q[rd_ptr];
                    INADDRESS <= addr_q[rd_ptr];
                end
            end else if (bypass) begin
                WRITE     <= 1'b1;
                IN        <= MD_DATA;
                INADDRESS <= MD_ADDR;
            end else begin
                WRITE <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Bench for reg_writeback_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_reg_writeback_arbiter;
    localparam int DW = 32, AW = 5, DEPTH = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic pipe_write = 0, md_valid = 0;
    logic [AW-1:0] pipe_addr = '0, md_addr = '0;
    logic [DW-1:0] pipe_data = '0, md_data = '0;
    logic md_ready, wr;
    logic [DW-1:0] in_dat;
    logic [AW-1:0] in_addr;
    logic [(1<<AW)-1:0] pending;
    logic [$clog2(DEPTH):0] count;

    reg_writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .CLK(clk), .RESET(rst_n), .PIPE_WRITE(pipe_write), .PIPE_ADDR(pipe_addr), .PIPE_DATA(pipe_data),
        .MD_VALID(md_valid), .MD_READY(md_ready), .MD_ADDR(md_addr), .MD_DATA(md_data),
        .IN(in_dat), .INADDRESS(in_addr), .WRITE(wr), .PENDING(pending), .COUNT(count));

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; bit live; } ent_t;
    ent_t m_q[$];
    bit m_write, m_xfer;
    logic [DW-1:0] m_in;
    logic [AW-1:0] m_addr;
    int n_checks = 0, n_pass = 0;

    function automatic logic [(1<<AW)-1:0] m_pending();
        logic [(1<<AW)-1:0] p = '0;
        foreach (m_q[i]) if (m_q[i].live) p[m_q[i].addr] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        m_q.delete(); m_write = 0; m_in = '0; m_addr = '0; m_xfer = 0;
    endtask

    // Advance the reference model by one clock using the inputs currently applied.
    task automatic model_step();
        bit preq, byp;
        ent_t e;
        m_xfer = md_valid && rst_n && (m_q.size() != DEPTH);
        preq = pipe_write && (pipe_addr != 0);
        byp = 0;
        if (preq) foreach (m_q[i]) if (m_q[i].addr == pipe_addr) m_q[i].live = 0;
        if (preq) begin
            m_write = 1; m_in = pipe_data; m_addr = pipe_addr;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_write = e.live;
            if (e.live) begin m_in = e.data; m_addr = e.addr; end
        end else if (BYP && m_xfer && md_addr != 0) begin
            byp = 1; m_write = 1; m_in = md_data; m_addr = md_addr;
        end else begin
            m_write = 0;
        end
        if (m_xfer && md_addr != 0 && !byp) begin
            e.addr = md_addr; e.data = md_data; e.live = !(preq && pipe_addr == md_addr);
            m_q.push_back(e);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        pipe_write = 0; pipe_addr = '0; pipe_data = '0; md_valid = 0; md_addr = '0; md_data = '0;
    endtask

    task automatic test_reset();
        set_idle(); rst_n = 0; model_reset();
        @(negedge clk);
        n_checks++; if (wr !== 1'b0) $display("FAIL rst_write got=%b exp=0", wr); else n_pass++;
        n_checks++; if (in_dat !== '0 || in_addr !== '0) $display("FAIL rst_in got=%0d/%0d exp=0/0", in_dat, in_addr); else n_pass++;
        n_checks++; if (pending !== '0 || count !== '0) $display("FAIL rst_state pend=%h cnt=%0d exp=0/0", pending, count); else n_pass++;
        n_checks++; if (md_ready !== 1'b0) $display("FAIL rst_ready got=%b exp=0", md_ready); else n_pass++;
        rst_n = 1; #1;
        n_checks++; if (md_ready !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", md_ready); else n_pass++;
    endtask

    task automatic test_pipe_write();
        pipe_write = 1; pipe_addr = 5'd2; pipe_data = 32'd95;
        cycle(); set_idle();
        n_checks++; if (wr !== 1'b1 || in_addr !== 5'd2 || in_dat !== 32'd95)
            $display("FAIL pipe_write got=%b a=%0d d=%0d exp=1 a=2 d=95", wr, in_addr, in_dat); else n_pass++;
        cycle();
        n_checks++; if (wr !== 1'b0) $display("FAIL pipe_one_cycle got=%b exp=0", wr); else n_pass++;
    endtask

    task automatic test_md_single();
        md_valid = 1; md_addr = 5'd1; md_data = 32'd28;
        cycle(); set_idle();
        if (BYP) begin
            n_checks++; if (wr !== 1'b1 || in_dat !== 32'd28 || count !== '0)
                $display("FAIL md_bypass got w=%b d=%0d c=%0d exp w=1 d=28 c=0", wr, in_dat, count); else n_pass++;
            cycle();
            n_checks++; if (wr !== 1'b0) $display("FAIL md_bypass_end got=%b exp=0", wr); else n_pass++;
        end else begin
            n_checks++; if (wr !== 1'b0 || count !== 3'd1 || pending[1] !== 1'b1)
                $display("FAIL md_queued got w=%b c=%0d p1=%b exp w=0 c=1 p1=1", wr, count, pending[1]); else n_pass++;
            cycle();
            n_checks++; if (wr !== 1'b1 || in_dat !== 32'd28 || in_addr !== 5'd1 || count !== '0 || pending[1] !== 1'b0)
                $display("FAIL md_drain got w=%b d=%0d a=%0d c=%0d p1=%b", wr, in_dat, in_addr, count, pending[1]); else n_pass++;
        end
        cycle();
    endtask

    task automatic test_starve();
        int idx = 0;
        for (int k = 0; k < 7; k++) begin
            pipe_write = 1; pipe_addr = 5'd7; pipe_data = 32'(k);
            md_valid = (idx < 4); md_addr = 5'(3 + idx); md_data = 32'(100 + idx);
            cycle();
            if (m_xfer) idx++;
        end
        set_idle();
        n_checks++; if (count !== 3'd4 || md_ready !== 1'b0)
            $display("FAIL starve_full got c=%0d rdy=%b exp c=4 rdy=0", count, md_ready); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_checks++; if (wr !== 1'b1 || in_addr !== 5'(3 + k) || in_dat !== 32'(100 + k))
                $display("FAIL starve_order%0d got w=%b a=%0d d=%0d exp a=%0d", k, wr, in_addr, in_dat, 3 + k); else n_pass++;
        end
        n_checks++; if (count !== '0) $display("FAIL starve_empty got=%0d exp=0", count); else n_pass++;
        cycle();
    endtask

    task automatic test_kill();
        pipe_write = 1; pipe_addr = 5'd9; pipe_data = 32'd1; md_valid = 1; md_addr = 5'd4; md_data = 32'd6;
        cycle(); set_idle();
        n_checks++; if (pending[4] !== 1'b1 || count !== 3'd1) $display("FAIL kill_pend got p4=%b c=%0d exp 1/1", pending[4], count); else n_pass++;
        pipe_write = 1; pipe_addr = 5'd4; pipe_data = 32'd15;
        cycle(); set_idle();
        n_checks++; if (pending[4] !== 1'b0 || wr !== 1'b1 || in_dat !== 32'd15 || in_addr !== 5'd4)
            $display("FAIL kill_write got p4=%b w=%b d=%0d a=%0d exp 0/1/15/4", pending[4], wr, in_dat, in_addr); else n_pass++;
        cycle();
        n_checks++; if (wr !== 1'b0 || count !== '0) $display("FAIL kill_pop got w=%b c=%0d exp 0/0", wr, count); else n_pass++;
    endtask

    task automatic test_same_cycle();
        pipe_write = 1; pipe_addr = 5'd5; pipe_data = 32'd50; md_valid = 1; md_addr = 5'd5; md_data = 32'd7;
        cycle(); set_idle();
        n_checks++; if (wr !== 1'b1 || in_dat !== 32'd50 || pending[5] !== 1'b0)
            $display("FAIL same_pipe got w=%b d=%0d p5=%b exp 1/50/0", wr, in_dat, pending[5]); else n_pass++;
        cycle();
        n_checks++; if (wr !== 1'b0 || count !== '0) $display("FAIL same_dead got w=%b c=%0d exp 0/0", wr, count); else n_pass++;
    endtask

    task automatic test_zero();
        md_valid = 1; md_addr = '0; md_data = 32'd99;
        cycle(); set_idle();
        n_checks++; if (wr !== 1'b0 || count !== '0 || md_ready !== 1'b1)
            $display("FAIL zero_md got w=%b c=%0d rdy=%b exp 0/0/1", wr, count, md_ready); else n_pass++;
        pipe_write = 1; pipe_addr = '0; pipe_data = 32'd77;
        cycle(); set_idle();
        n_checks++; if (wr !== 1'b0 || count !== '0) $display("FAIL zero_pipe got w=%b c=%0d exp 0/0", wr, count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            pipe_write = 1; pipe_addr = 5'd9; pipe_data = 32'(k); md_valid = 1; md_addr = 5'(1 + k); md_data = 32'(k);
            cycle();
        end
        set_idle();
        n_checks++; if (count !== 3'd3) $display("FAIL midrst_fill got=%0d exp=3", count); else n_pass++;
        #2 rst_n = 0; model_reset(); #1;
        n_checks++; if (count !== '0 || pending !== '0 || wr !== 1'b0)
            $display("FAIL midrst_clear got c=%0d p=%h w=%b exp 0/0/0", count, pending, wr); else n_pass++;
        @(negedge clk); rst_n = 1;
        cycle();
        n_checks++; if (wr !== 1'b0 || count !== '0) $display("FAIL midrst_after got w=%b c=%0d exp 0/0", wr, count); else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            pipe_write = ($urandom_range(0, 99) < 45);
            pipe_addr = 5'($urandom_range(0, 7)); pipe_data = $urandom;
            if (!(md_valid && !m_xfer)) begin
                md_valid = ($urandom_range(0, 99) < 60);
                md_addr = 5'($urandom_range(0, 7)); md_data = $urandom;
            end
            cycle();
            n_checks++; if (wr !== m_write) $display("FAIL rnd_write@%0d got=%b exp=%b", k, wr, m_write); else n_pass++;
            if (m_write) begin
                n_checks++; if (in_dat !== m_in || in_addr !== m_addr)
                    $display("FAIL rnd_data@%0d got %0d/%h exp %0d/%h", k, in_addr, in_dat, m_addr, m_in); else n_pass++;
            end
            n_checks++; if (count !== 3'(m_q.size())) $display("FAIL rnd_count@%0d got=%0d exp=%0d", k, count, m_q.size()); else n_pass++;
            n_checks++; if (pending !== m_pending()) $display("FAIL rnd_pending@%0d got=%h exp=%h", k, pending, m_pending()); else n_pass++;
            n_checks++; if (md_ready !== (m_q.size() != DEPTH)) $display("FAIL rnd_ready@%0d got=%b", k, md_ready); else n_pass++;
        end
        set_idle();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_pipe_write();
        test_md_single();
        test_starve();
        test_kill();
        test_same_cycle();
        test_zero();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
